// File: rtl/ds_pkg.sv
// ds_pkg: shared widths, counter limits and types for the decode-stage controller.
package ds_pkg;
   localparam int INST_W    = 16;
   localparam int NREG      = 4;
   localparam int REG_IDX_W = 2;
   localparam int CNT_W     = 2;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   typedef logic [REG_IDX_W-1:0] reg_idx_t;
   typedef logic [CNT_W-1:0] cnt_t;
   typedef enum logic {EMPTY, FULL} stage_t;
endpackage

// File: rtl/ds_ctrl_if.sv
// ds_ctrl_if: fetch/decoder/execute/writeback signals seen by the decode-stage controller.
interface ds_ctrl_if;
   import ds_pkg::*;
   logic              fs_valid;
   logic [INST_W-1:0] fs_to_ds_bus;
   logic              ds_allowin;
   logic [INST_W-1:0] ds_inst;
   reg_idx_t          ds_rx;
   reg_idx_t          ds_ry;
   logic              ds_rd_rx;
   logic              ds_rd_ry;
   logic              ds_we;
   reg_idx_t          ds_dest;
   logic              ds_to_es_valid;
   logic              es_allowin;
   logic              wb_we;
   reg_idx_t          wb_dest;
   logic              flush;
   logic              ds_stall;
   logic [NREG-1:0]   busy;
   modport slave (
      input  fs_valid, fs_to_ds_bus, ds_rx, ds_ry, ds_rd_rx, ds_rd_ry, ds_we, ds_dest,
             es_allowin, wb_we, wb_dest, flush,
      output ds_allowin, ds_inst, ds_to_es_valid, ds_stall, busy
   );
   modport master (
      output fs_valid, fs_to_ds_bus, ds_rx, ds_ry, ds_rd_rx, ds_rd_ry, ds_we, ds_dest,
             es_allowin, wb_we, wb_dest, flush,
      input  ds_allowin, ds_inst, ds_to_es_valid, ds_stall, busy
   );
endinterface

// File: rtl/ds_scoreboard.sv
// ds_scoreboard: per-register in-flight write counters with issue increment and writeback decrement.
module ds_scoreboard
   import ds_pkg::*;
(
   input  logic            clk,
   input  logic            resetn,
   input  logic            inc_i,
   input  reg_idx_t        inc_idx_i,
   input  logic            dec_i,
   input  reg_idx_t        dec_idx_i,
   input  reg_idx_t        rx_i,
   input  reg_idx_t        ry_i,
   input  reg_idx_t        dest_i,
   output cnt_t            cnt_rx_o,
   output cnt_t            cnt_ry_o,
   output cnt_t            cnt_dest_o,
   output logic [NREG-1:0] busy_o
);
   cnt_t [NREG-1:0] cnt_q, cnt_d;
   logic [NREG-1:0] up, dn;
   // simultaneous issue and retire on one register cancel; retire at zero is dropped
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         up[i]     = inc_i && inc_idx_i == reg_idx_t'(i);
         dn[i]     = dec_i && dec_idx_i == reg_idx_t'(i);
         cnt_d[i]  = (up[i] && !dn[i]) ? cnt_q[i] + 1'b1 :
                     (dn[i] && !up[i] && cnt_q[i] != '0) ? cnt_q[i] - 1'b1 : cnt_q[i];
         busy_o[i] = cnt_q[i] != '0;
      end
   end
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) cnt_q <= '0;
      else cnt_q <= cnt_d;
   assign cnt_rx_o   = cnt_q[rx_i];
   assign cnt_ry_o   = cnt_q[ry_i];
   assign cnt_dest_o = cnt_q[dest_i];
endmodule

// File: rtl/ds_ctrl.sv
// ds_ctrl: ID-stage pipeline register, hazard check and valid/allowin handshake.
// Optional DS_CTRL_STALL_CNT_EN adds a saturating stall-cycle counter output.
module ds_ctrl
   import ds_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   ds_ctrl_if.slave    bus
`ifdef DS_CTRL_STALL_CNT_EN
   ,
   output logic [15:0] stall_cnt
`endif
);
   stage_t            state_q, state_d;
   logic [INST_W-1:0] ds_inst_q, ds_inst_d;
   logic              full, hazard, ready_go, es_fire;
   cnt_t              cnt_rx, cnt_ry, cnt_dest;
   assign full     = state_q == FULL;
   // registered counts only: a stalled reader issues the cycle after its count reaches zero
   assign hazard   = full && ((bus.ds_rd_rx && cnt_rx != '0) || (bus.ds_rd_ry && cnt_ry != '0) ||
                              (bus.ds_we && cnt_dest == CNT_MAX));
   assign ready_go = !hazard;
   assign bus.ds_stall       = full && hazard;
   assign bus.ds_to_es_valid = full && ready_go && !bus.flush;
   assign bus.ds_allowin     = !full || (ready_go && bus.es_allowin);
   assign bus.ds_inst        = ds_inst_q;
   assign es_fire  = bus.ds_to_es_valid && bus.es_allowin;
   always_comb begin
      state_d   = bus.ds_allowin ? (bus.fs_valid ? FULL : EMPTY) : bus.flush ? EMPTY : state_q;
      ds_inst_d = (bus.ds_allowin && bus.fs_valid) ? bus.fs_to_ds_bus : ds_inst_q;
   end
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         state_q   <= EMPTY;
         ds_inst_q <= '0;
      end else begin
         state_q   <= state_d;
         ds_inst_q <= ds_inst_d;
      end
   ds_scoreboard u_sb (
      .clk        (clk),
      .resetn     (resetn),
      .inc_i      (es_fire && bus.ds_we),
      .inc_idx_i  (bus.ds_dest),
      .dec_i      (bus.wb_we),
      .dec_idx_i  (bus.wb_dest),
      .rx_i       (bus.ds_rx),
      .ry_i       (bus.ds_ry),
      .dest_i     (bus.ds_dest),
      .cnt_rx_o   (cnt_rx),
      .cnt_ry_o   (cnt_ry),
      .cnt_dest_o (cnt_dest),
      .busy_o     (bus.busy)
   );
`ifdef DS_CTRL_STALL_CNT_EN
   logic [15:0] stall_cnt_q;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) stall_cnt_q <= '0;
      else if (bus.ds_stall && !bus.flush && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
   assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_ds_ctrl.sv
// tb_ds_ctrl: directed bench for ds_ctrl; issued instructions are checked against a queue of expected issues.
module tb_ds_ctrl;
   import ds_pkg::*;
   logic clk = 1'b0;
   logic resetn;
   logic dec_en;
   int   n_chk = 0;
   int   n_err = 0;
   logic [15:0] exp_q[$];
   ds_ctrl_if bus();
`ifdef DS_CTRL_STALL_CNT_EN
   logic [15:0] stall_cnt;
   ds_ctrl dut (.clk(clk), .resetn(resetn), .bus(bus.slave), .stall_cnt(stall_cnt));
`else
   ds_ctrl dut (.clk(clk), .resetn(resetn), .bus(bus.slave));
`endif
   always #5 clk = ~clk;

   // stand-in decoder: fields taken from the latched instruction
   always_comb begin
      bus.ds_rd_rx = dec_en & bus.ds_inst[15];
      bus.ds_rd_ry = dec_en & bus.ds_inst[14];
      bus.ds_we    = dec_en & bus.ds_inst[13];
      bus.ds_rx    = bus.ds_inst[11:10];
      bus.ds_ry    = bus.ds_inst[9:8];
      bus.ds_dest  = bus.ds_inst[5:4];
   end

   function automatic logic [15:0] mk(logic rdx, logic rdy, logic we, logic [1:0] rx, logic [1:0] ry,
                                      logic [1:0] dst, logic [3:0] tag);
      return {rdx, rdy, we, 1'b0, rx, ry, 2'b00, dst, tag};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [15:0] inst, input bit will_issue);
      bus.fs_valid     = 1'b1;
      bus.fs_to_ds_bus = inst;
      if (will_issue) exp_q.push_back(inst);
      step();
      bus.fs_valid = 1'b0;
   endtask

   always @(negedge clk)
      if (resetn && bus.ds_to_es_valid && bus.es_allowin) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $error("FAIL issue_extra observed=%0h expected=none", bus.ds_inst);
         end else check("issue", 32'(bus.ds_inst), 32'(exp_q.pop_front()));
      end

   initial begin
      logic [15:0] w, r, x;
      resetn = 1'b0; dec_en = 1'b0;
      bus.fs_valid = 1'b0; bus.fs_to_ds_bus = '0; bus.es_allowin = 1'b1;
      bus.wb_we = 1'b0; bus.wb_dest = '0; bus.flush = 1'b0;
      step(); step();
      check("rst_allowin", 32'(bus.ds_allowin), 32'd1);
      check("rst_to_es", 32'(bus.ds_to_es_valid), 32'd0);
      check("rst_stall", 32'(bus.ds_stall), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_inst", 32'(bus.ds_inst), 32'd0);
      resetn = 1'b1;
      step();
      // plain flow, back-to-back
      fetch(16'hABCD, 1);
      check("flow_inst1", 32'(bus.ds_inst), 32'hABCD);
      check("flow_valid1", 32'(bus.ds_to_es_valid), 32'd1);
      fetch(16'h5678, 1);
      check("flow_inst2", 32'(bus.ds_inst), 32'h5678);
      check("flow_valid2", 32'(bus.ds_to_es_valid), 32'd1);
      check("flow_allowin", 32'(bus.ds_allowin), 32'd1);
      step();
      check("flow_drain", 32'(bus.ds_to_es_valid), 32'd0);
      // RAW on r1
      dec_en = 1'b1;
      w = mk(0, 0, 1, 2'd0, 2'd0, 2'd1, 4'h1);
      r = mk(1, 0, 0, 2'd1, 2'd0, 2'd0, 4'h2);
      fetch(w, 1);
      fetch(r, 1);
      check("raw_busy", 32'(bus.busy), 32'b0010);
      check("raw_stall", 32'(bus.ds_stall), 32'd1);
      check("raw_allowin", 32'(bus.ds_allowin), 32'd0);
      check("raw_to_es", 32'(bus.ds_to_es_valid), 32'd0);
      step();
      check("raw_hold", 32'(bus.ds_inst), 32'(r));
      bus.wb_we = 1'b1; bus.wb_dest = 2'd1;
      step();
      bus.wb_we = 1'b0;
      check("raw_release", 32'(bus.ds_stall), 32'd0);
      check("raw_issue", 32'(bus.ds_to_es_valid), 32'd1);
      check("raw_busy0", 32'(bus.busy), 32'd0);
      step();
      // counter saturation on r3
      for (int i = 1; i <= 4; i++) fetch(mk(0, 0, 1, 2'd0, 2'd0, 2'd3, 4'(i)), 1);
      check("sat_busy", 32'(bus.busy), 32'b1000);
      check("sat_stall", 32'(bus.ds_stall), 32'd1);
      check("sat_allowin", 32'(bus.ds_allowin), 32'd0);
      bus.wb_we = 1'b1; bus.wb_dest = 2'd3;
      step();
      bus.wb_we = 1'b0;
      check("sat_release", 32'(bus.ds_stall), 32'd0);
      check("sat_issue", 32'(bus.ds_to_es_valid), 32'd1);
      step();
      check("sat_busy_again", 32'(bus.busy), 32'b1000);
      bus.wb_we = 1'b1;
      step(); step(); step();
      bus.wb_we = 1'b0;
      check("sat_drain", 32'(bus.busy), 32'd0);
      // issue and retire on r0 together
      fetch(mk(0, 0, 1, 2'd0, 2'd0, 2'd0, 4'h5), 1);
      step();
      check("sim_busy1", 32'(bus.busy), 32'b0001);
      fetch(mk(0, 0, 1, 2'd0, 2'd0, 2'd0, 4'h6), 1);
      bus.wb_we = 1'b1; bus.wb_dest = 2'd0;
      step();
      bus.wb_we = 1'b0;
      check("sim_busy_same", 32'(bus.busy), 32'b0001);
      bus.wb_we = 1'b1;
      step();
      bus.wb_we = 1'b0;
      check("sim_busy0", 32'(bus.busy), 32'd0);
      // backpressure
      bus.es_allowin = 1'b0;
      x = mk(0, 0, 0, 2'd0, 2'd0, 2'd0, 4'hA);
      fetch(x, 1);
      check("bp_valid", 32'(bus.ds_to_es_valid), 32'd1);
      check("bp_allowin", 32'(bus.ds_allowin), 32'd0);
      step();
      check("bp_hold", 32'(bus.ds_inst), 32'(x));
      check("bp_valid2", 32'(bus.ds_to_es_valid), 32'd1);
      bus.es_allowin = 1'b1;
      step();
      check("bp_drain", 32'(bus.ds_to_es_valid), 32'd0);
      // reset with a held instruction and cnt[2]=1
      w = mk(0, 0, 1, 2'd0, 2'd0, 2'd2, 4'h7);
      fetch(w, 1);
      step();
      bus.es_allowin = 1'b0;
      fetch(mk(0, 0, 0, 2'd0, 2'd0, 2'd0, 4'h8), 0);
      check("pre_rst_busy", 32'(bus.busy), 32'b0100);
      check("pre_rst_valid", 32'(bus.ds_to_es_valid), 32'd1);
      resetn = 1'b0;
      step();
      check("mid_rst_allowin", 32'(bus.ds_allowin), 32'd1);
      check("mid_rst_to_es", 32'(bus.ds_to_es_valid), 32'd0);
      check("mid_rst_busy", 32'(bus.busy), 32'd0);
      check("mid_rst_inst", 32'(bus.ds_inst), 32'd0);
`ifdef DS_CTRL_STALL_CNT_EN
      check("mid_rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
      resetn = 1'b1; bus.es_allowin = 1'b1;
      step();
      // flush while stalled on r2
      r = mk(1, 0, 0, 2'd2, 2'd0, 2'd0, 4'h9);
      fetch(w, 1);
      fetch(r, 0);
      check("fl_stall", 32'(bus.ds_stall), 32'd1);
      check("fl_busy", 32'(bus.busy), 32'b0100);
      repeat (5) step();
      bus.flush = 1'b1;
      check("fl_to_es", 32'(bus.ds_to_es_valid), 32'd0);
      step();
      bus.flush = 1'b0;
      check("fl_empty", 32'(bus.ds_allowin), 32'd1);
      check("fl_stall0", 32'(bus.ds_stall), 32'd0);
      check("fl_to_es0", 32'(bus.ds_to_es_valid), 32'd0);
      check("fl_busy_kept", 32'(bus.busy), 32'b0100);
`ifdef DS_CTRL_STALL_CNT_EN
      check("stall_cnt", 32'(stall_cnt), 32'd5);
`endif
      bus.wb_we = 1'b1; bus.wb_dest = 2'd2;
      step();
      bus.wb_we = 1'b0;
      check("fl_busy0", 32'(bus.busy), 32'd0);
      step();
      check("issue_q_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/ds_ctrl.md
Name: ds_ctrl

Overview:
- Pipeline controller for the decode (ID) stage of the 8-bit teaching CPU.
- Holds the IF→ID pipeline register and feeds the latched instruction to the combinational decoder.
- Runs a per-register scoreboard for read-after-write and write-count hazards, and drives the valid/allowin handshake on both sides.
- Sits between the fetch stage and the execute stage, alongside the decoder.

Parameters:
- INST_W, 16, instruction/fs_to_ds_bus width
- NREG, 4, architectural registers (index width log2(NREG)=2)
- CNT_W, 2, per-register in-flight write counter width; CNT_MAX = 2**CNT_W-1 = 3

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- fs_valid  in  1  fetch stage holds a valid instruction
- fs_to_ds_bus  in  INST_W  instruction from fetch
- ds_allowin  out  1  ID can accept from fetch this cycle
- ds_inst  out  INST_W  latched instruction, drives the decoder input
- ds_rx  in  2  decoder source index rx
- ds_ry  in  2  decoder source index ry
- ds_rd_rx  in  1  instruction reads rx
- ds_rd_ry  in  1  instruction reads ry
- ds_we  in  1  instruction writes a register
- ds_dest  in  2  destination index
- ds_to_es_valid  out  1  ID presents a valid instruction to EX
- es_allowin  in  1  EX accepts this cycle
- wb_we  in  1  writeback retires a register write
- wb_dest  in  2  writeback register index
- flush  in  1  kill the instruction currently in ID
- ds_stall  out  1  ID valid but held by hazard
- busy  out  NREG  busy[i] = cnt[i] != 0

Behaviour:
- Reset, asynchronous on resetn low:
  - ds_valid=0, ds_inst=0, all cnt=0.
  - Outputs: ds_allowin=1, ds_to_es_valid=0, ds_stall=0, busy=0.
  - Reset mid-operation discards the held instruction and all scoreboard state.
- Stage state is ds_valid: EMPTY(0) or FULL(1).
- hazard = ds_valid & ((ds_rd_rx & cnt[ds_rx]!=0) | (ds_rd_ry & cnt[ds_ry]!=0) | (ds_we & cnt[ds_dest]==CNT_MAX)).
- ready_go = ~hazard; ds_stall = ds_valid & hazard.
- ds_to_es_valid = ds_valid & ready_go & ~flush.
- ds_allowin = ~ds_valid | (ready_go & es_allowin); combinational, no flush term.
- es_fire = ds_to_es_valid & es_allowin.
- Clock edge, in priority order:
  - flush: ds_valid<=0 (FULL→EMPTY). The same-cycle fetch is still accepted if ds_allowin & fs_valid, and the new instruction loads as valid.
  - Else if ds_allowin: ds_valid<=fs_valid.
  - If ds_allowin & fs_valid: ds_inst<=fs_to_ds_bus. Otherwise ds_inst holds, stable throughout a stall.
- Scoreboard, per register i:
  - inc = es_fire & ds_we & ds_dest==i; dec = wb_we & wb_dest==i.
  - inc&~dec → +1; dec&~inc → −1; both → unchanged.
  - dec at 0 is ignored and the counter stays 0.
  - inc at CNT_MAX cannot occur, because hazard blocks it.
- Hazard check uses registered counts, with no bypass. An instruction stalled on reg r issues the cycle after the writeback that takes cnt[r] to 0. Minimum RAW stall = cycles until WB + 1.
- flush never alters counters; instructions already in EX and beyond still write back.
- An instruction reading and writing the same register checks the read against pre-issue counts only.
- Indices are 2 bits; no out-of-range case.

Optional Feature:
- Macro DS_CTRL_STALL_CNT_EN.
- Defined:
  - Extra output stall_cnt [15:0] counts cycles with ds_stall=1.
  - Resets to 0 and saturates at 16'hFFFF.
  - Flush cycles are not counted.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package ds_pkg: INST_W, NREG, REG_IDX_W=2, CNT_W, CNT_MAX, and a reg_idx_t typedef.
- One sub-module, ds_scoreboard: NREG counters with inc/dec ports, cnt read for three indices, and the busy vector.
- ds_ctrl keeps the handshake, pipeline register and hazard logic.

Test Plan:
- Reset: drive resetn=0 mid-run with ds_valid=1 and cnt[2]=1 → next sample ds_allowin=1, ds_to_es_valid=0, busy=4'b0000, ds_inst=16'h0000.
- Flow: fs_valid=1, fs_to_ds_bus=16'hABCD, es_allowin=1, no reads/writes → ds_inst=16'hABCD one cycle later, ds_to_es_valid=1; back-to-back 16'h5678 passes with no bubble.
- RAW stall:
  - Issue a write to r1 → busy=4'b0010.
  - Next instruction with ds_rd_rx=1, ds_rx=1 → ds_stall=1, ds_allowin=0, ds_inst held.
  - Pulse wb_we=1, wb_dest=1 → ds_stall falls the following cycle and the instruction issues.
- Saturation: three issued writes to r3 with no writeback → cnt[3]=3; a fourth write to r3 stalls; one wb to r3 releases it.
- Simultaneous: es_fire writing r0 in the same cycle as wb_we to r0 with cnt[0]=1 → cnt[0] stays 1. Backpressure: es_allowin=0 → ds_to_es_valid=1 held, ds_allowin=0.
- Flush:
  - flush=1 while stalled → ds_valid=0 next cycle, counters unchanged, ds_to_es_valid=0 during the flush cycle.
  - With DS_CTRL_STALL_CNT_EN defined, stall_cnt equals the observed stall cycles (e.g. 5).
